// File: rtl/instr_loader.sv
// Instruction memory loader: streams 32-bit words in, writes them out as four big-endian byte writes.
// Optional LOADER_CHECKSUM_EN adds a running XOR of accepted words on the Checksum port.
module instr_loader #(
    parameter int MEM_BYTES = 36,
    parameter int ADDR_W    = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Word_valid,
    input  logic [31:0]       Word_data,
    input  logic              Word_last,
    output logic              Word_ready,
    output logic              Mem_we,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [7:0]        Mem_wdata,
    output logic              Busy,
    output logic              Done,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]       Checksum,
`endif
    output logic              Overflow
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(MEM_BYTES);

    state_t            state_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        k_q;
    logic [23:0]       rest_q;
    logic              last_q;
    logic              ready_q, we_q, busy_q, done_q, ovf_q;
    logic [7:0]        wdata_q;
    logic              hs;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       csum_q;
`endif

    assign base_d = base_q + ADDR_W'(4);
    assign hs     = Word_valid & ready_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            rest_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_q <= S_ACCEPT;
                        base_q  <= '0;
                        k_q     <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                S_ACCEPT: begin
                    // Byte 0 leaves straight from the bus; the remaining three are shifted out of rest_q.
                    if (hs) begin
                        state_q <= S_WRITE;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        addr_q  <= base_q;
                        wdata_q <= Word_data[31:24];
                        rest_q  <= Word_data[23:0];
                        last_q  <= Word_last;
                        k_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ Word_data;
`endif
                    end
                end
                S_WRITE: begin
                    if (k_q == 2'd3) begin
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        base_q  <= base_d;
                        if (last_q || base_d == END_ADDR) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ACCEPT;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        k_q     <= k_q + 2'd1;
                        addr_q  <= addr_q + ADDR_W'(1);
                        wdata_q <= rest_q[23:16];
                        rest_q  <= {rest_q[15:0], 8'h00};
                    end
                end
                S_DONE: begin
                    if (Start) begin
                        state_q <= S_ACCEPT;
                        base_q  <= '0;
                        k_q     <= '0;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end else if (Word_valid) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Word_ready = ready_q;
    assign Mem_we     = we_q;
    assign Mem_addr   = addr_q;
    assign Mem_wdata  = wdata_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Overflow   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    assign Checksum   = csum_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Randomized and directed bench for instr_loader; expected byte writes come from a word-list model.
module tb_instr_loader;

    localparam int MEM = 36;

    logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0;
    logic        Word_valid = 1'b0, Word_last = 1'b0;
    logic [31:0] Word_data = '0;
    logic        Word_ready, Mem_we, Busy, Done, Overflow;
    logic [31:0] Mem_addr;
    logic [7:0]  Mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] Checksum;
`endif

    instr_loader #(.MEM_BYTES(MEM), .ADDR_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Word_valid(Word_valid),
        .Word_data(Word_data), .Word_last(Word_last), .Word_ready(Word_ready),
        .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
        .Busy(Busy), .Done(Done),
`ifdef LOADER_CHECKSUM_EN
        .Checksum(Checksum),
`endif
        .Overflow(Overflow));

    always #5 Clk = ~Clk;

    typedef struct {int addr; int data; int cyc;} wr_t;

    int   cyc = 0, total = 0, bad = 0, oob = 0, zviol = 0, done_cyc = 0;
    wr_t  wr_q[$], exp_q[$];
    int   hs_cyc[$];

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Mem_we) begin
            wr_q.push_back('{int'(Mem_addr), int'(Mem_wdata), cyc});
            if (Mem_addr >= MEM) oob++;
        end else if (Mem_addr != 0 || Mem_wdata != 0) zviol++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input bit hold, output bit ok);
        ok = 0; Word_valid = 1'b1; Word_data = d; Word_last = l;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge Clk);
            if (Word_ready) begin @(posedge Clk); #1; ok = 1; end
        end
        if (!hold || !ok) begin Word_valid = 1'b0; Word_last = 1'b0; end
    endtask

    task automatic load_image(input logic [31:0] w[$], input bit l[$], input int glo, input int ghi,
                              input bit start_mid);
        bit ok; int g; bit hold;
        hs_cyc.delete();
        for (int i = 0; i < w.size(); i++) begin
            g = $urandom_range(ghi, glo);
            if (g > 0) begin repeat (g) @(posedge Clk); #1; end
            hold = (ghi == 0) && !start_mid && (i != w.size() - 1);
            send(w[i], l[i], hold, ok);
            chk("handshake", ok, 1);
            hs_cyc.push_back(cyc);
            if (start_mid && i != w.size() - 1) begin
                pulse_start();                   // lands in WRITE
                repeat (4) @(posedge Clk); #1;
                pulse_start();                   // lands in ACCEPT
            end
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge Clk);
            if (Done) begin seen = 1; done_cyc = cyc; end
        end
        chk("done_timeout", seen, 1);
    endtask

    // Each accepted word i becomes bytes 4i..4i+3, MSB first; stop on last or a full memory.
    task automatic check_writes(input string tag, input logic [31:0] w[$], input bit l[$]);
        int nacc = 0;
        exp_q.delete();
        for (int i = 0; i < w.size(); i++) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back('{4*i + k, int'((w[i] >> (24 - 8*k)) & 32'hFF), 0});
            nacc++;
            if (l[i] || 4*(i+1) >= MEM) break;
        end
        chk({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        if (wr_q.size() == exp_q.size()) begin
            foreach (exp_q[j]) begin
                chk($sformatf("%s_addr%0d", tag, j), wr_q[j].addr, exp_q[j].addr);
                chk($sformatf("%s_data%0d", tag, j), wr_q[j].data, exp_q[j].data);
            end
            for (int i = 0; i < nacc; i++) begin
                chk($sformatf("%s_b0cyc%0d", tag, i), wr_q[4*i].cyc, hs_cyc[i]);
                chk($sformatf("%s_b3cyc%0d", tag, i), wr_q[4*i+3].cyc, hs_cyc[i] + 3);
            end
            chk({tag, "_donecyc"}, done_cyc, wr_q[wr_q.size()-1].cyc + 1);
        end
        wr_q.delete();
    endtask

    initial begin
        logic [31:0] w[$];
        bit          l[$];
        bit          ok;
        int          n;
        logic [31:0] xr;

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ready", Word_ready, 0); chk("rst_we", Mem_we, 0);
        chk("rst_addr", Mem_addr, 0);   chk("rst_wdata", Mem_wdata, 0);
        chk("rst_busy", Busy, 0);       chk("rst_done", Done, 0);
        chk("rst_ovf", Overflow, 0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("idle_ready", Word_ready, 0);
        @(posedge Clk); #1;

        // Full image, valid held high, no Word_last: the memory size ends the load.
        pulse_start();
        @(negedge Clk);
        chk("start_ready", Word_ready, 1); chk("start_busy", Busy, 1);
        @(posedge Clk); #1;
        w.delete(); l.delete();
        for (int i = 0; i < 9; i++) begin w.push_back(32'(i)); l.push_back(1'b0); end
        load_image(w, l, 0, 0, 0);
        wait_done();
        if (wr_q.size() > 7) begin
            chk("full_a4", wr_q[4].data, 8'h00);
            chk("full_a7", wr_q[7].data, 8'h01);
        end
        check_writes("full", w, l);
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("full_ready0", Word_ready, 0); chk("full_done", Done, 1); chk("full_busy", Busy, 0);
        end

        // Overflow: valid in DONE is dropped and latched; Start clears it.
        @(posedge Clk); #1;
        Word_valid = 1'b1; Word_data = 32'hDEADBEEF;
        repeat (2) @(posedge Clk); #1;
        Word_valid = 1'b0;
        @(negedge Clk);
        chk("ovf_set", Overflow, 1); chk("ovf_nowrite", wr_q.size(), 0); chk("ovf_done", Done, 1);
        @(posedge Clk); #1;
        pulse_start();
        @(negedge Clk);
        chk("ovf_clr", Overflow, 0); chk("ovf_done_clr", Done, 0); chk("ovf_ready", Word_ready, 1);
        @(posedge Clk); #1;

        // Byte order on a single-word image.
        w = '{32'h20080005}; l = '{1'b1};
        load_image(w, l, 0, 0, 0);
        wait_done();
        check_writes("order", w, l);
        for (int c = 0; c < 4; c++) begin @(negedge Clk); chk("order_busy", Busy, 0); end
        @(posedge Clk); #1;

        // Backpressure: two idle valid cycles between words.
        pulse_start();
        w.delete(); l.delete();
        for (int i = 0; i < 4; i++) begin w.push_back($urandom); l.push_back(i == 3); end
        load_image(w, l, 2, 2, 0);
        wait_done();
        check_writes("bp", w, l);
        @(posedge Clk); #1;

        // Start during WRITE and ACCEPT must not disturb the load.
        pulse_start();
        w = '{32'hA1B2C3D4, 32'h55667788, 32'h0BADF00D}; l = '{1'b0, 1'b0, 1'b1};
        load_image(w, l, 0, 0, 1);
        wait_done();
        check_writes("startign", w, l);
        @(posedge Clk); #1;

        // Randomized images.
        for (int t = 0; t < 6; t++) begin
            pulse_start();
            n = $urandom_range(9, 1);
            w.delete(); l.delete(); xr = '0;
            for (int i = 0; i < n; i++) begin
                w.push_back($urandom);
                l.push_back((i == n - 1) ? ((n < 9) ? 1'b1 : 1'($urandom_range(1, 0))) : 1'b0);
                xr ^= w[i];
            end
            load_image(w, l, 0, 3, 0);
            wait_done();
            check_writes($sformatf("rnd%0d", t), w, l);
`ifdef LOADER_CHECKSUM_EN
            chk($sformatf("rnd%0d_csum", t), Checksum, xr);
`endif
            @(posedge Clk); #1;
        end

        // Reset during byte 2 of word 3 (address 14).
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(32'h11111111 * (i + 1), 1'b0, 1'b0, ok);
            chk("mid_hs", ok, 1);
        end
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge Clk);
            if (Mem_we && Mem_addr == 14) ok = 1;
        end
        chk("mid_reach", ok, 1);
        Reset = 1'b0;
        #1;
        chk("mid_we", Mem_we, 0);     chk("mid_addr", Mem_addr, 0);
        chk("mid_wdata", Mem_wdata, 0); chk("mid_ready", Word_ready, 0);
        chk("mid_busy", Busy, 0);     chk("mid_done", Done, 0);
        chk("mid_ovf", Overflow, 0);
`ifdef LOADER_CHECKSUM_EN
        chk("mid_csum", Checksum, 0);
`endif
        @(posedge Clk); #1;
        Reset = 1'b1;
        wr_q.delete();
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("post_idle_ready", Word_ready, 0); chk("post_idle_busy", Busy, 0);
        @(posedge Clk); #1;
        pulse_start();
        w = '{32'hCAFE0123}; l = '{1'b1};
        load_image(w, l, 0, 0, 0);
        wait_done();
        check_writes("reload", w, l);
        @(posedge Clk); #1;

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        @(negedge Clk);
        chk("csum_clr", Checksum, 0);
        @(posedge Clk); #1;
        w = '{32'h12345678, 32'h0F0F0F0F}; l = '{1'b0, 1'b1};
        load_image(w, l, 0, 0, 0);
        wait_done();
        chk("csum_val", Checksum, 32'h1D3B5977);
        check_writes("csum", w, l);
`endif

        chk("no_oob_write", oob, 0);
        chk("idle_bus_zero", zviol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that writes the instruction memory from a 32-bit word stream, the write-side counterpart of the instruction fetch path. Accepts instruction words over a valid/ready handshake and writes each word into the byte-wide instruction memory as four big-endian byte writes: byte address A gets bits 31:24, and A+3 gets bits 7:0. This matches the fetch-side concatenation Mem[PC], Mem[PC+1], Mem[PC+2], Mem[PC+3]. The block sits between a host/test stream and the instruction memory's write port, and holds the core off (Busy) until the image is loaded.

## Interface
Parameters:
- MEM_BYTES, 36, instruction memory size in bytes; must be a multiple of 4.
- ADDR_W, 32, width of Mem_addr (byte address, same width as PC).

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  single-cycle request to begin a load at byte address 0.
- Word_valid  input  1  Word_data/Word_last are valid.
- Word_data  input  32  instruction word.
- Word_last  input  1  marks final word of image; qualified by Word_valid.
- Word_ready  output  1  loader can accept a word this cycle.
- Mem_we  output  1  byte write strobe to instruction memory.
- Mem_addr  output  ADDR_W  byte write address.
- Mem_wdata  output  8  byte write data.
- Busy  output  1  load in progress (ACCEPT or WRITE).
- Done  output  1  image complete; held until next Start or reset.
- Overflow  output  1  sticky: Word_valid seen while in DONE.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: Word_ready=0, Busy=0. Start=1 -> ACCEPT, base address := 0, byte index := 0.
- ACCEPT: Word_ready=1, Busy=1. Handshake (Word_valid & Word_ready): latch Word_data and Word_last, then go to WRITE. Without a handshake, stay.
- WRITE: Word_ready=0, Busy=1, Mem_we=1 for 4 consecutive cycles.
  - Byte k (0..3) goes to Mem_addr = base+k, with Mem_wdata = word[31-8k : 24-8k].
  - After k=3, base += 4.
  - If the latched Word_last=1 or the new base == MEM_BYTES, go to DONE. Otherwise go to ACCEPT.
- DONE: Done=1, Busy=0, Word_ready=0.
  - Word_valid=1 sets Overflow (sticky). The word is dropped and nothing is written.
  - Start=1 -> ACCEPT: base := 0, Done := 0, Overflow := 0.
- Start in ACCEPT or WRITE is ignored. A load is never truncated by Start.
- The memory size is reached exactly at base == MEM_BYTES. No wrap-around: an address ≥ MEM_BYTES is never driven with Mem_we=1.
- Mem_addr and Mem_wdata are 0 whenever Mem_we=0.

## Timing
- Reset asserted (low), at any time including mid-WRITE: state := IDLE immediately.
  - Mem_we, Word_ready, Busy, Done, Overflow, Mem_addr, Mem_wdata (and Checksum) = 0.
  - Memory contents written so far are left as-is. The memory itself is not cleared.
- Start at edge n -> Word_ready=1 from cycle n+1.
- Handshake at edge n -> byte 0 write in cycle n+1, byte 3 in cycle n+4. Word_ready=1 again in cycle n+5 if not finished.
- Peak throughput: 1 word per 5 cycles. A full 36-byte image loads in ≥45 cycles after Start.
- Done rises in the cycle after the byte-3 write of the final word.
- Outputs are registered; no combinational path from Word_valid to Word_ready.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Adds output Checksum (32 bits) = running XOR of every accepted word.
  - Cleared to 0 on reset and on the Start that leaves IDLE/DONE.
  - Updated at the handshake edge.
- Not defined: no Checksum port and no checksum register. All other behaviour is identical.

## Test plan
- Full image: Start, then stream 9 words 0x00000000..0x00000008 with Word_valid held high. Expect:
  - 36 writes, with Mem_addr 0..35 in order.
  - Address 4 gets 0x00, address 7 gets 0x01.
  - Done=1 after the last write; Word_ready=0 from then on.
- Byte order: single word 0x20080005 with Word_last=1. Expect writes (0,0x20), (1,0x08), (2,0x00), (3,0x05), then Done, with Busy low for the rest of the run.
- Backpressure: Word_valid toggled 1-0-0-1 between words. Expect no write while Word_valid=0 in ACCEPT, no dropped or duplicated word, and correct final addresses.
- Overflow: after a full 9-word load, hold Word_valid=1 for 2 cycles. Expect Overflow=1, no Mem_we; a following Start clears Done and Overflow.
- Reset mid-operation: assert Reset low during byte 2 of word 3. Expect all outputs 0 at once and state IDLE. After release, Start reloads from address 0.
- With LOADER_CHECKSUM_EN: words 0x12345678 and 0x0F0F0F0F -> Checksum = 0x1D3B5977.
